// File: rtl/data_mem_mmio.sv
// Data-side memory for the 5-stage core: word RAM plus MMIO (UART TX with FIFO,
// status register, free-running cycle counter). Load data is returned combinationally.
module data_mem_mmio #(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic        re,
  output logic        uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [FW:0]   FIFO_FULL_C = (FW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST_C  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  logic [31:0]   ram_r [RAM_WORDS];
  logic [7:0]    fifo_r [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr_r, wr_ptr_r;
  logic [FW:0]   count_r;
  logic          overflow_r;
  logic [31:0]   cycle_r;
  state_t        state_r;
  logic [CW-1:0] bit_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;

  logic          ram_hit_s, mmio_hit_s;
  logic [AW-1:0] ram_idx_s;
  logic [1:0]    reg_sel_s;
  logic          wr_tx_s, wr_status_s, wr_cycle_s;
  logic          fifo_empty_s, fifo_full_s, tx_busy_s, bit_end_s, pop_s, push_ok_s;
  logic          unused_s;

  assign ram_hit_s    = (addr[31:AW+2] == '0);
  assign mmio_hit_s   = (addr[31:4] == 28'h1000_000);
  assign ram_idx_s    = addr[AW+1:2];
  assign reg_sel_s    = addr[3:2];
  assign wr_tx_s      = we & mmio_hit_s & (reg_sel_s == 2'd0);
  assign wr_status_s  = we & mmio_hit_s & (reg_sel_s == 2'd1);
  assign wr_cycle_s   = we & mmio_hit_s & (reg_sel_s == 2'd2);
  assign fifo_empty_s = (count_r == '0);
  assign fifo_full_s  = (count_r == FIFO_FULL_C);
  assign tx_busy_s    = (state_r != IDLE);
  assign bit_end_s    = (bit_cnt_r == BIT_LAST_C);
  // A pop happens exactly when the UART loads a byte: from IDLE or at the end of STOP.
  assign pop_s        = ~fifo_empty_s & ((state_r == IDLE) | ((state_r == STOP) & bit_end_s));
  assign push_ok_s    = wr_tx_s & (~fifo_full_s | pop_s);
  assign uart_tx      = tx_r;
  assign unused_s     = &{1'b0, addr[1:0]};

  // Load data mux
  always_comb begin
    rdata = 32'd0;
    if (re) begin
      if (ram_hit_s) begin
        rdata = ram_r[ram_idx_s];
      end else if (mmio_hit_s) begin
        case (reg_sel_s)
          2'd1:    rdata = {27'd0, 1'b0, overflow_r, fifo_empty_s, fifo_full_s, tx_busy_s};
          2'd2:    rdata = cycle_r;
          default: rdata = 32'd0;
        endcase
      end else begin
        rdata = 32'd0;
      end
    end else begin
      rdata = 32'd0;
    end
  end

  // RAM store port (contents survive reset)
  always_ff @(posedge clk) begin
    if (we && ram_hit_s) ram_r[ram_idx_s] <= wdata;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_s) fifo_r[wr_ptr_r] <= wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + FW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + FW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (FW+1)'(1);
        2'b01:   count_r <= count_r - (FW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag and cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
      cycle_r    <= 32'd0;
    end else begin
      if (wr_tx_s && !push_ok_s)      overflow_r <= 1'b1;
      else if (wr_status_s && wdata[3]) overflow_r <= 1'b0;
      if (wr_cycle_s) cycle_r <= wdata;
      else            cycle_r <= cycle_r + 32'd1;
    end
  end

  // UART 8N1 transmitter FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            shift_r   <= fifo_r[rd_ptr_r];
            bit_cnt_r <= '0;
            tx_r      <= 1'b0;
            state_r   <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            bit_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= DATA;
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            bit_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            bit_cnt_r <= '0;
            if (pop_s) begin
              shift_r <= fifo_r[rd_ptr_r];
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: RAM model, UART line receiver and
// per-feature scenario tasks with inline comparisons.
module tb_data_mem_mmio;
  localparam logic [31:0] A_TX = 32'h1000_0000;
  localparam logic [31:0] A_ST = 32'h1000_0004;
  localparam logic [31:0] A_CY = 32'h1000_0008;
  localparam logic [31:0] A_RS = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        uart_tx;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_rel = 0;
  logic [31:0] ram_model [int];

  always #5 clk = ~clk;

  data_mem_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rdata(rdata),
    .we(we), .re(re), .uart_tx(uart_tx)
  );

  // Line receiver: 4 clocks per bit, samples mid-bit on falling edges.
  logic [7:0] rx_q [$];
  int         rx_start_q [$];
  int         rx_bad = 0;
  int         cyc = 0;
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rx_active <= 1'b0;
    end else if (rx_active) begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 1) % 4) == 0) begin
        rx_sh <= {uart_tx, rx_sh[7:1]};
      end else if (rx_cnt == 37) begin
        if (uart_tx !== 1'b1) rx_bad <= rx_bad + 1;
        rx_q.push_back(rx_sh);
        rx_active <= 1'b0;
      end
    end else if (uart_tx === 1'b0) begin
      rx_active <= 1'b1;
      rx_cnt    <= 1;
      rx_start_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    cyc_rel = cyc;
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    addr = A_ST; re = 1'b1; #1;
    n_cmp++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h expected %h", rdata, 32'h4); end
    addr = A_CY; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cycle: got %h expected 0", rdata); end
    re = 1'b0;
  endtask

  task automatic test_ram();
    int idx_q [$];
    int idx;
    logic [31:0] w;
    re = 1'b0;
    addr = 32'h10; wdata = 32'hDEAD_BEEF; we = 1'b1; ram_model[4] = 32'hDEAD_BEEF; step();
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(16, 1023);
      w = $urandom;
      addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      wdata = w; we = 1'b1;
      ram_model[idx] = w;
      idx_q.push_back(idx);
      step();
    end
    we = 1'b0; re = 1'b1;
    addr = 32'h10; #1;
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_10: got %h expected deadbeef", rdata); end
    addr = 32'h13; #1;
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_13: got %h expected deadbeef", rdata); end
    addr = 32'h1000; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL ram_oob: got %h expected 0", rdata); end
    addr = 32'h2000_0010; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h expected 0", rdata); end
    addr = A_TX; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL txdata_rd: got %h expected 0", rdata); end
    addr = A_RS; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reserved_rd: got %h expected 0", rdata); end
    foreach (idx_q[k]) begin
      addr = (32'(idx_q[k]) << 2) | 32'($urandom_range(0, 3)); #1;
      n_cmp++;
      if (rdata !== ram_model[idx_q[k]]) begin
        n_fail++; $display("FAIL ram_rand: addr %h got %h expected %h", addr, rdata, ram_model[idx_q[k]]);
      end
    end
    re = 1'b0; addr = 32'h10; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL re_low: got %h expected 0", rdata); end
    step();
    w = $urandom;
    addr = 32'h10; wdata = w; we = 1'b1; re = 1'b1; #1;
    n_cmp++; if (rdata !== ram_model[4]) begin n_fail++; $display("FAIL rw_same_cycle: got %h expected %h", rdata, ram_model[4]); end
    step();
    we = 1'b0; ram_model[4] = w; #1;
    n_cmp++; if (rdata !== ram_model[4]) begin n_fail++; $display("FAIL rw_after: got %h expected %h", rdata, ram_model[4]); end
    re = 1'b0;
  endtask

  task automatic test_single_tx();
    logic [7:0] b;
    logic [9:0] fr;
    int rb;
    b = 8'($urandom);
    fr = {1'b1, b, 1'b0};
    rb = rx_q.size();
    step();
    addr = A_TX; wdata = {24'($urandom), b}; we = 1'b1; re = 1'b0;
    step();
    we = 1'b0; addr = A_ST; re = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++; if (uart_tx !== fr[i/4]) begin n_fail++; $display("FAIL tx_bit[%0d]: got %b expected %b", i, uart_tx, fr[i/4]); end
      n_cmp++; if (rdata !== 32'h5) begin n_fail++; $display("FAIL tx_status_busy[%0d]: got %h expected 5", i, rdata); end
    end
    step();
    n_cmp++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL tx_status_done: got %h expected 4", rdata); end
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle: got %b expected 1", uart_tx); end
    n_cmp++; if (rx_q.size() !== rb + 1) begin n_fail++; $display("FAIL tx_rx_count: got %0d expected %0d", rx_q.size(), rb + 1); end
    else begin
      n_cmp++; if (rx_q[rb] !== b) begin n_fail++; $display("FAIL tx_rx_byte: got %h expected %h", rx_q[rb], b); end
    end
    re = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rb, sb, waited;
    rb = rx_q.size(); sb = rx_start_q.size();
    re = 1'b0; addr = A_TX; we = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wdata = 32'(k);
      step();
    end
    wdata = 32'hAA;
    step();
    we = 1'b0; addr = A_ST; re = 1'b1; #1;
    n_cmp++; if (rdata !== 32'hB) begin n_fail++; $display("FAIL b2b_status: got %h expected b", rdata); end
    waited = 0;
    while (rx_q.size() < rb + 9 && waited < 500) begin
      step(); waited++;
    end
    n_cmp++; if (rx_q.size() !== rb + 9) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", rx_q.size() - rb, 9); end
    for (int k = 0; k < 9; k++) begin
      if (rb + k < rx_q.size()) begin
        n_cmp++; if (rx_q[rb+k] !== 8'(k + 1)) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h expected %h", k, rx_q[rb+k], 8'(k + 1)); end
      end
    end
    for (int k = 1; k < 9; k++) begin
      if (sb + k < rx_start_q.size()) begin
        n_cmp++;
        if (rx_start_q[sb+k] - rx_start_q[sb+k-1] !== 40) begin
          n_fail++; $display("FAIL b2b_gap[%0d]: got %0d expected 40", k, rx_start_q[sb+k] - rx_start_q[sb+k-1]);
        end
      end
    end
    n_cmp++; if (rx_bad !== 0) begin n_fail++; $display("FAIL stop_bits: got %0d bad expected 0", rx_bad); end
    repeat (5) step();
    n_cmp++; if (rdata !== 32'hC) begin n_fail++; $display("FAIL b2b_status_end: got %h expected c", rdata); end
    re = 1'b0;
  endtask

  task automatic test_overflow_clear();
    addr = A_ST; re = 1'b1; we = 1'b1; wdata = $urandom & 32'hFFFF_FFF7;
    step();
    we = 1'b0; #1;
    n_cmp++; if (rdata[3] !== 1'b1) begin n_fail++; $display("FAIL ovf_keep: got %b expected 1", rdata[3]); end
    we = 1'b1; wdata = 32'h8;
    step();
    we = 1'b0; #1;
    n_cmp++; if (rdata[3] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", rdata[3]); end
    re = 1'b0;
  endtask

  task automatic test_cycle();
    logic [31:0] r;
    step();
    addr = A_CY; re = 1'b1; we = 1'b0; #1;
    n_cmp++; if (rdata !== 32'(cyc - cyc_rel)) begin n_fail++; $display("FAIL cycle_free: got %h expected %h", rdata, 32'(cyc - cyc_rel)); end
    wdata = 32'hFFFF_FFFE; we = 1'b1; #1;
    n_cmp++; if (rdata !== 32'(cyc - cyc_rel)) begin n_fail++; $display("FAIL cycle_wr_old: got %h expected %h", rdata, 32'(cyc - cyc_rel)); end
    step();
    we = 1'b0; #1;
    n_cmp++; if (rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cycle_load: got %h expected fffffffe", rdata); end
    step();
    n_cmp++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_ff: got %h expected ffffffff", rdata); end
    step();
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap: got %h expected 0", rdata); end
    step();
    n_cmp++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL cycle_after_wrap: got %h expected 1", rdata); end
    r = $urandom;
    wdata = r; we = 1'b1;
    step();
    we = 1'b0;
    step();
    n_cmp++; if (rdata !== r + 32'd1) begin n_fail++; $display("FAIL cycle_rand: got %h expected %h", rdata, r + 32'd1); end
    re = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] w;
    w = $urandom;
    addr = 32'h40; wdata = w; we = 1'b1; re = 1'b0; ram_model[16] = w;
    step();
    addr = A_TX; wdata = 32'h5A;
    step();
    wdata = 32'hC3;
    step();
    we = 1'b0;
    repeat (18) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", uart_tx); end
    addr = A_CY; re = 1'b1; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_cycle: got %h expected 0", rdata); end
    addr = A_ST; #1;
    n_cmp++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL rstmid_status: got %h expected 4", rdata); end
    addr = 32'h40; #1;
    n_cmp++; if (rdata !== ram_model[16]) begin n_fail++; $display("FAIL rstmid_ram: got %h expected %h", rdata, ram_model[16]); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_quiet[%0d]: got %b expected 1", i, uart_tx); end
    end
    re = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_single_tx();
    test_back_to_back();
    test_overflow_clear();
    test_cycle();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
